// File: rtl/instr_fetch_if.sv
// Instruction fetch bus bundle.
// Groups the instruction-memory port, the decode handshake, the decoded
// instruction fields, the redirect request and the accepted-instruction count.
//   master : the fetch unit (drives imem request, instruction and fields)
//   slave  : memory / decode / control side
interface instr_fetch_if;
    // instruction memory
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    // decode handshake
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    // decoded fields
    logic [3:0]  opcode;
    logic [2:0]  func;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  rd;
    logic [15:0] imm16;
    logic [15:0] jaddr;
    // control-flow redirect
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    // statistics
    logic [15:0] instr_count;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rdata,
        output instr_valid, instr, instr_pc,
        input  instr_ready,
        output opcode, func, ra, rb, rd, imm16, jaddr,
        input  redirect_valid, redirect_pc,
        output instr_count
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rdata,
        input  instr_valid, instr, instr_pc,
        output instr_ready,
        input  opcode, func, ra, rb, rd, imm16, jaddr,
        output redirect_valid, redirect_pc,
        input  instr_count
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit.
// Fetches one 16-bit word at a time from instruction memory, holds it in the
// instruction register until decode accepts it, and exposes the decoded
// fields combinationally. A redirect flushes the held/incoming instruction
// and restarts fetch at the new address.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : instr_fetch_if.master (imem bus, decode handshake, fields,
//          redirect, instr_count)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | just out of reset, no request outstanding
// FETCH | imem_req=1 at imem_addr=pc, waiting for imem_ready
// VALID | instruction register valid, waiting for instr_ready
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic           clk,
    input  logic           rst,
    instr_fetch_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] instr_pc_q, instr_pc_d;
    logic [15:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 16'h0000;
            instr_pc_q <= 16'h0000;
            count_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_d         = instr_q;
        instr_pc_d      = instr_pc_q;
        count_d         = count_q;
        bus.imem_req    = 1'b0;
        bus.imem_addr   = 16'h0000;
        bus.instr_valid = 1'b0;

        case (state_q)
            IDLE: begin
                // redirect is deliberately ignored here
                state_d = FETCH;
            end
            FETCH: begin
                bus.imem_req  = 1'b1;
                bus.imem_addr = pc_q;
                if (bus.redirect_valid) begin
                    // a response arriving with the redirect is dropped
                    pc_d    = bus.redirect_pc;
                    state_d = FETCH;
                end else if (bus.imem_ready) begin
                    instr_d    = bus.imem_rdata;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + 16'd1;  // wraps modulo 2^16
                    state_d    = VALID;
                end
            end
            VALID: begin
                bus.instr_valid = 1'b1;
                if (bus.redirect_valid) begin
                    pc_d    = bus.redirect_pc;
                    state_d = FETCH;
                end else if (bus.instr_ready) begin
                    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_count = count_q;
    assign bus.opcode      = instr_q[15:12];
    assign bus.ra          = instr_q[11:9];
    assign bus.rb          = instr_q[8:6];
    assign bus.rd          = instr_q[5:3];
    assign bus.func        = instr_q[2:0];
    assign bus.imm16       = {{10{instr_q[5]}}, instr_q[5:0]};
    assign bus.jaddr       = {instr_pc_q[15:12], instr_q[11:0]};

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
// The bench drives memory responses itself; each accepted response is pushed
// onto a scoreboard with the bench's own expected fetch address, and popped
// and compared when decode handshakes the instruction. A second instance
// with RESET_PC=16'hFFFF exercises address wrap.
module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instr_fetch_if m();
    instr_fetch_if w();

    instr_fetch #(.RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m.master)
    );

    instr_fetch #(.RESET_PC(16'hFFFF)) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (w.master)
    );

    typedef struct {
        logic [15:0] ins;
        logic [15:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] exp_pc;
    logic [15:0] exp_count;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a zero-wait response in the current FETCH cycle.
    task automatic respond(input logic [15:0] data);
        chk("fetch_req", {15'd0, m.imem_req}, 16'd1);
        chk("fetch_addr", m.imem_addr, exp_pc);
        m.imem_ready = 1'b1;
        m.imem_rdata = data;
        sb.push_back('{data, exp_pc});
        exp_pc = exp_pc + 16'd1;
        tick();
        m.imem_ready = 1'b0;
        chk("resp_valid", {15'd0, m.instr_valid}, 16'd1);
        chk("resp_noreq", {15'd0, m.imem_req}, 16'd0);
    endtask

    // Handshake the held instruction and check it against the scoreboard.
    task automatic handshake();
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $error("FAIL sb_empty: observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            chk("hs_instr", m.instr, e.ins);
            chk("hs_pc", m.instr_pc, e.pc);
        end
        m.instr_ready = 1'b1;
        tick();
        m.instr_ready = 1'b0;
        exp_count = (exp_count == 16'hFFFF) ? exp_count : exp_count + 16'd1;
        chk("hs_count", m.instr_count, exp_count);
        chk("hs_novalid", {15'd0, m.instr_valid}, 16'd0);
        chk("hs_next_addr", m.imem_addr, exp_pc);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   {15'd0, m.imem_req}, 16'd0);
        chk({tag, "_addr"},  m.imem_addr, 16'h0000);
        chk({tag, "_valid"}, {15'd0, m.instr_valid}, 16'd0);
        chk({tag, "_instr"}, m.instr, 16'h0000);
        chk({tag, "_ipc"},   m.instr_pc, 16'h0000);
        chk({tag, "_count"}, m.instr_count, 16'h0000);
    endtask

    initial begin
        rst              = 1'b1;
        m.imem_ready     = 1'b0;
        m.imem_rdata     = 16'h0000;
        m.instr_ready    = 1'b0;
        m.redirect_valid = 1'b0;
        m.redirect_pc    = 16'h0000;
        w.imem_ready     = 1'b1;
        w.imem_rdata     = 16'h1111;
        w.instr_ready    = 1'b1;
        w.redirect_valid = 1'b0;
        w.redirect_pc    = 16'h0000;

        tick();
        tick();
        chk_reset("rst");

        // reset dominates all other inputs
        m.imem_ready     = 1'b1;
        m.imem_rdata     = 16'hFFFF;
        m.instr_ready    = 1'b1;
        m.redirect_valid = 1'b1;
        m.redirect_pc    = 16'h2222;
        tick();
        chk_reset("rst_hold");
        m.imem_ready  = 1'b0;
        m.instr_ready = 1'b0;

        // cycle 0: IDLE, redirect ignored
        exp_pc    = 16'h0000;
        exp_count = 16'h0000;
        rst = 1'b0;
        m.redirect_pc = 16'h1234;
        chk("idle_req", {15'd0, m.imem_req}, 16'd0);
        chk("wrap_idle_req", {15'd0, w.imem_req}, 16'd0);
        tick();
        m.redirect_valid = 1'b0;

        // cycle 1: first request at RESET_PC
        chk("wrap_addr0", w.imem_addr, 16'hFFFF);
        respond(16'h0A43);
        // cycle 2: decode of 0A43
        chk("dec_opcode", {12'd0, m.opcode}, 16'd0);
        chk("dec_func", {13'd0, m.func}, 16'd3);
        chk("dec_ra", {13'd0, m.ra}, 16'd5);
        chk("dec_rb", {13'd0, m.rb}, 16'd1);
        chk("dec_rd", {13'd0, m.rd}, 16'd0);
        chk("wrap_valid", {15'd0, w.instr_valid}, 16'd1);
        chk("wrap_ipc", w.instr_pc, 16'hFFFF);
        handshake();
        chk("wrap_addr1", w.imem_addr, 16'h0000);

        // 3 wait cycles, then 5-cycle decode stall
        for (int i = 0; i < 3; i++) begin
            chk("wait_req", {15'd0, m.imem_req}, 16'd1);
            chk("wait_addr", m.imem_addr, exp_pc);
            tick();
        end
        respond(16'h4BFE);
        chk("imm16", m.imm16, 16'hFFFE);
        chk("addi_opcode", {12'd0, m.opcode}, 16'd4);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {15'd0, m.instr_valid}, 16'd1);
            chk("stall_instr", m.instr, 16'h4BFE);
            chk("stall_ipc", m.instr_pc, 16'h0001);
            chk("stall_imm", m.imm16, 16'hFFFE);
            chk("stall_count", m.instr_count, exp_count);
            tick();
        end
        handshake();

        // redirect coinciding with a memory response: data dropped
        m.redirect_valid = 1'b1;
        m.redirect_pc    = 16'h0040;
        m.imem_ready     = 1'b1;
        m.imem_rdata     = 16'hDEAD;
        tick();
        m.redirect_valid = 1'b0;
        m.imem_ready     = 1'b0;
        exp_pc = 16'h0040;
        chk("redir_valid", {15'd0, m.instr_valid}, 16'd0);
        chk("redir_addr", m.imem_addr, 16'h0040);
        chk("redir_count", m.instr_count, exp_count);
        chk("redir_instr", m.instr, 16'h4BFE);

        // back-to-back redirects, last wins
        m.redirect_valid = 1'b1;
        m.redirect_pc    = 16'h1111;
        tick();
        m.redirect_pc    = 16'h5000;
        tick();
        m.redirect_valid = 1'b0;
        exp_pc = 16'h5000;
        respond(16'h2123);
        chk("jaddr", m.jaddr, 16'h5123);
        chk("j_opcode", {12'd0, m.opcode}, 16'd2);

        // redirect in VALID with instr_ready: no count, instruction flushed
        m.redirect_valid = 1'b1;
        m.redirect_pc    = 16'h0100;
        m.instr_ready    = 1'b1;
        tick();
        m.redirect_valid = 1'b0;
        m.instr_ready    = 1'b0;
        void'(sb.pop_front());
        exp_pc = 16'h0100;
        chk("vredir_count", m.instr_count, exp_count);
        chk("vredir_valid", {15'd0, m.instr_valid}, 16'd0);
        chk("vredir_addr", m.imem_addr, 16'h0100);

        // unrecognised opcode passes through unchanged
        respond(16'hF00F);
        chk("unk_opcode", {12'd0, m.opcode}, 16'hF);
        handshake();

        // saturation: preload count close to the limit
        dut.count_q = 16'hFFFD;
        exp_count   = 16'hFFFD;
        respond(16'h1234);
        handshake();
        respond(16'h5678);
        handshake();
        respond(16'h9ABC);
        handshake();
        chk("sat_count", m.instr_count, 16'hFFFF);

        // reset during a memory wait; late ready ignored
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m.imem_ready = 1'b1;
        m.imem_rdata = 16'hBEEF;
        chk_reset("midrst");
        tick();
        m.imem_ready = 1'b0;
        sb.delete();
        exp_pc    = 16'h0000;
        exp_count = 16'h0000;
        chk("late_valid", {15'd0, m.instr_valid}, 16'd0);
        chk("late_instr", m.instr, 16'h0000);
        respond(16'h3333);
        handshake();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: first fetch address after reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port imem_req, output, 1: fetch request to instruction memory.
REQ-005 SHALL have port imem_addr, output, 16: word address of the fetch.
REQ-006 SHALL have port imem_ready, input, 1: memory returns imem_rdata this cycle.
REQ-007 SHALL have port imem_rdata, input, 16: fetched instruction word.
REQ-008 SHALL have port instr_valid, output, 1: instruction register holds an instruction for decode.
REQ-009 SHALL have port instr_ready, input, 1: decode or control unit accepts the instruction.
REQ-010 SHALL have port instr, output, 16: instruction register.
REQ-011 SHALL have port instr_pc, output, 16: address of instr.
REQ-012 SHALL have port opcode, output, 4: instr[15:12].
REQ-013 SHALL have port func, output, 3: instr[2:0].
REQ-014 SHALL have port ra, rb and rd, output, 3 each: instr[11:9], instr[8:6] and instr[5:3].
REQ-015 SHALL have port imm16, output, 16: instr[5:0] sign-extended.
REQ-016 SHALL have port jaddr, output, 16: {instr_pc[15:12], instr[11:0]}.
REQ-017 SHALL have port redirect_valid, input, 1: branch or jump taken; flush and refetch.
REQ-018 SHALL have port redirect_pc, input, 16: new fetch address.
REQ-019 SHALL have port instr_count, output, 16: accepted-instruction count.

Function
REQ-020 SHALL implement states IDLE, FETCH and VALID.
REQ-021 IDLE SHALL move to FETCH unconditionally on the first cycle after rst deasserts.
REQ-022 FETCH SHALL drive imem_req=1 and imem_addr=pc.
REQ-023 FETCH SHALL hold imem_addr stable until imem_ready.
REQ-024 FETCH SHALL accept a response in the same cycle as the request (zero-wait memory).
REQ-025 In FETCH with imem_ready=1, the block SHALL load instr<=imem_rdata and instr_pc<=pc.
REQ-026 In FETCH with imem_ready=1, the block SHALL set pc<=pc+1 and move to VALID.
REQ-027 pc+1 SHALL be modulo 2^16, so 16'hFFFF wraps to 16'h0000.
REQ-028 VALID SHALL drive instr_valid=1 and imem_req=0.
REQ-029 instr and all decoded fields SHALL remain stable while instr_valid=1 and instr_ready=0.
REQ-030 In VALID with instr_ready=1 (handshake), the block SHALL move to FETCH on the next cycle.
REQ-031 On a handshake, instr_count SHALL increment by 1, saturating at 16'hFFFF.
REQ-032 Sustained throughput SHALL be at most one instruction per 2 cycles with zero-wait memory.
REQ-033 A handshake and a new fetch SHALL never occur in the same cycle.
REQ-034 opcode, func, ra, rb, rd, imm16 and jaddr SHALL be combinational from instr and instr_pc only.
REQ-035 redirect_valid=1 in FETCH or VALID SHALL set pc<=redirect_pc and instr_valid<=0, and move to FETCH next cycle.
REQ-036 On redirect, any imem_rdata returned in that same cycle SHALL be discarded.
REQ-037 On redirect, instr_count SHALL NOT increment, even if instr_ready=1 that cycle.
REQ-038 redirect_valid SHALL be ignored in IDLE.
REQ-039 Priority SHALL be rst > redirect_valid > handshake or memory response.
REQ-040 Back-to-back redirects SHALL each restart fetch, with the last redirect_pc winning.
REQ-041 An instruction whose opcode is not recognised SHALL be presented unchanged; the block does not decode legality.

Reset
REQ-042 rst=1 SHALL force state=IDLE, pc=RESET_PC, imem_req=0 and imem_addr=0 at the next edge.
REQ-043 rst=1 SHALL also force instr_valid=0, instr=16'h0000, instr_pc=16'h0000 and instr_count=0 at the next edge.
REQ-044 rst asserted mid-fetch SHALL abandon the outstanding request; a late imem_ready SHALL be ignored.
REQ-045 While rst=1, all outputs SHALL hold their reset values regardless of the other inputs.

Verification
REQ-046 Reset then zero-wait memory returning 16'h0A43 at addr 0, instr_ready=1 -> first request at cycle 1 (addr 0); instr_valid at cycle 2; opcode=0, func=3, ra=5, rb=1, rd=0; instr_count=1 after the handshake; next request addr 1.
REQ-047 Memory with 3 wait cycles, instr_ready=0 for 5 cycles -> imem_addr stable through the wait; instr and instr_pc stable while valid; exactly one handshake once ready rises.
REQ-048 Response 16'h4BFE (ADDI, imm 6'b111110) -> imm16=16'hFFFE; response 16'h2123 at instr_pc 16'h5000 -> jaddr=16'h5123.
REQ-049 redirect_valid with redirect_pc=16'h0040 in the same cycle as imem_ready -> data dropped; instr_valid=0 next cycle; next imem_addr=16'h0040; instr_count unchanged.
REQ-050 RESET_PC=16'hFFFF with two fetches -> addresses 16'hFFFF then 16'h0000.
REQ-051 instr_count preloaded by 65535 handshakes, then one more handshake -> instr_count stays at 16'hFFFF.
REQ-052 rst pulse during a memory wait -> IDLE; the late imem_ready is ignored; fetch restarts at RESET_PC.
